// File: rtl/key_debounce_multi.sv
// -----------------------------------------------------------------------------
// key_debounce_multi
//
// N-channel push-button debouncer. Each raw key pin passes through a 2-flop
// synchroniser and is normalised so that 1 means "pressed". A small per-channel
// state machine then requires the key to be stable for DEBOUNCE_MS ticks of a
// shared 1 ms prescaler before it changes the debounced level.
//
// Optional feature, enabled by defining the macro KEY_DEBOUNCE_LONG_PRESS_EN:
// a one-cycle Long_Pulse fires once per press when the key has been held for
// LONG_MS ms after press confirmation. Without the macro, Long_Pulse is tied 0.
//
// Ports:
//   CLK           in   1       system clock
//   RSTn          in   1       asynchronous active-low reset
//   Key_In        in   N_KEYS  raw asynchronous key pins
//   Key_State     out  N_KEYS  debounced level, 1 = pressed
//   Press_Pulse   out  N_KEYS  one-cycle pulse on confirmed press
//   Release_Pulse out  N_KEYS  one-cycle pulse on confirmed release
//   Long_Pulse    out  N_KEYS  one-cycle pulse on long press
// -----------------------------------------------------------------------------
module key_debounce_multi #(
  parameter int N_KEYS      = 4,
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 10,
  parameter int ACTIVE_LOW  = 1,
  parameter int LONG_MS     = 1000
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [N_KEYS-1:0] Key_In,
  output logic [N_KEYS-1:0] Key_State,
  output logic [N_KEYS-1:0] Press_Pulse,
  output logic [N_KEYS-1:0] Release_Pulse,
  output logic [N_KEYS-1:0] Long_Pulse
);

  localparam int DIV    = CLK_HZ / 1000;
  localparam int PW     = $clog2(DIV);
  localparam int MAX_MS = (LONG_MS > DEBOUNCE_MS) ? LONG_MS : DEBOUNCE_MS;
  localparam int CW     = $clog2(MAX_MS + 1);

  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_MS - 1);
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_MS - 1);
  localparam logic [CW-1:0] LONG_SAT  = CW'(LONG_MS);
`endif

  // Synchroniser flops come out of reset at the released pin level so that a
  // key held through reset is seen as a fresh press and debounced normally.
  localparam logic [N_KEYS-1:0] IDLE_LEVEL =
    (ACTIVE_LOW != 0) ? {N_KEYS{1'b1}} : {N_KEYS{1'b0}};

  typedef enum logic [1:0] {
    UP     = 2'd0,
    CHK_DN = 2'd1,
    DOWN   = 2'd2,
    CHK_UP = 2'd3
  } state_t;

  logic [PW-1:0]     pre;
  logic              tick;
  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;
  logic [N_KEYS-1:0] pressed;

  // Shared free-running 1 ms prescaler; tick is high during the terminal count.
  assign tick = (pre == PRE_LAST);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync1 <= IDLE_LEVEL;
      sync2 <= IDLE_LEVEL;
    end else begin
      sync1 <= Key_In;
      sync2 <= sync1;
    end
  end

  assign pressed = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

  for (genvar ch = 0; ch < N_KEYS; ch++) begin : g_ch
    state_t        state;
    logic [CW-1:0] cnt;
    logic          level_q;
    logic          press_q;
    logic          rel_q;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    logic          long_q;
`endif

    // Check states count ticks while the input stays put; any reversal of
    // the input aborts the check immediately, even on a tick cycle.
    always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
        state   <= UP;
        cnt     <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
        long_q  <= 1'b0;
`endif
      end else begin
        press_q <= 1'b0;
        rel_q   <= 1'b0;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
        long_q  <= 1'b0;
`endif
        case (state)
          UP: begin
            if (pressed[ch]) begin
              state <= CHK_DN;
              cnt   <= '0;
            end
          end
          CHK_DN: begin
            if (!pressed[ch]) begin
              state <= UP;
            end else if (tick) begin
              if (cnt == DEB_LAST) begin
                state   <= DOWN;
                level_q <= 1'b1;
                press_q <= 1'b1;
                cnt     <= '0;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
          DOWN: begin
            if (!pressed[ch]) begin
              state <= CHK_UP;
              cnt   <= '0;
            end
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
            // Held-time count saturates at LONG_MS so the pulse fires once.
            else if (tick && (cnt != LONG_SAT)) begin
              cnt <= cnt + CW'(1);
              if (cnt == LONG_LAST) begin
                long_q <= 1'b1;
              end
            end
`endif
          end
          CHK_UP: begin
            if (pressed[ch]) begin
              state <= DOWN;
              cnt   <= '0;
            end else if (tick) begin
              if (cnt == DEB_LAST) begin
                state   <= UP;
                level_q <= 1'b0;
                rel_q   <= 1'b1;
                cnt     <= '0;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
          default: begin
            state <= UP;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign Key_State[ch]     = level_q;
    assign Press_Pulse[ch]   = press_q;
    assign Release_Pulse[ch] = rel_q;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    assign Long_Pulse[ch]    = long_q;
`endif
  end

`ifndef KEY_DEBOUNCE_LONG_PRESS_EN
  assign Long_Pulse = '0;
`endif

endmodule

// File: tb/tb_key_debounce_multi.sv
// -----------------------------------------------------------------------------
// tb_key_debounce_multi
//
// Directed bench for key_debounce_multi with a 10 cycle/ms clock, 3 ms
// debounce and 8 ms long press. A negedge monitor tallies pulses per channel
// and records the cycle each was seen; directed steps then compare those
// tallies and the debounced levels against hand-computed values.
// Long-press expectations follow KEY_DEBOUNCE_LONG_PRESS_EN.
// -----------------------------------------------------------------------------
module tb_key_debounce_multi;

  localparam int N = 4;

  logic         CLK = 1'b0;
  logic         RSTn = 1'b0;
  logic [N-1:0] Key_In = 4'hF;
  logic [N-1:0] Key_State;
  logic [N-1:0] Press_Pulse;
  logic [N-1:0] Release_Pulse;
  logic [N-1:0] Long_Pulse;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t0 = 0;

  int press_cnt [N];
  int rel_cnt   [N];
  int long_cnt  [N];
  int press_at  [N];
  int rel_at    [N];
  int long_at   [N];
  logic [N-1:0] press_vec;
  logic [N-1:0] rel_vec;

  key_debounce_multi #(
    .N_KEYS     (4),
    .CLK_HZ     (10_000),
    .DEBOUNCE_MS(3),
    .ACTIVE_LOW (1),
    .LONG_MS    (8)
  ) dut (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .Key_In       (Key_In),
    .Key_State    (Key_State),
    .Press_Pulse  (Press_Pulse),
    .Release_Pulse(Release_Pulse),
    .Long_Pulse   (Long_Pulse)
  );

  // 10 time-unit clock period
  always #5 CLK = ~CLK;

  // Posedge counter used to timestamp pulses and input changes
  always @(posedge CLK) cyc <= cyc + 1;

  // Pulse monitor, sampled mid-cycle away from the active edge
  always @(negedge CLK) begin
    if (RSTn) begin
      for (int i = 0; i < N; i++) begin
        if (Press_Pulse[i])   begin press_cnt[i]++; press_at[i] = cyc; end
        if (Release_Pulse[i]) begin rel_cnt[i]++;   rel_at[i]   = cyc; end
        if (Long_Pulse[i])    begin long_cnt[i]++;  long_at[i]  = cyc; end
      end
      if (Press_Pulse != '0)   press_vec = Press_Pulse;
      if (Release_Pulse != '0) rel_vec   = Release_Pulse;
    end
  end

  task automatic clearCounts();
    for (int i = 0; i < N; i++) begin
      press_cnt[i] = 0; rel_cnt[i] = 0; long_cnt[i] = 0;
      press_at[i] = 0;  rel_at[i] = 0;  long_at[i] = 0;
    end
    press_vec = '0;
    rel_vec   = '0;
  endtask

  // Drive the key pins just after an active edge and timestamp the change
  task automatic applyStimulus(input logic [N-1:0] keys);
    @(posedge CLK);
    #1;
    Key_In = keys;
    t0 = cyc;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int inWindow(input int d);
    return (d >= 23 && d <= 33) ? 1 : 0;
  endfunction

  function automatic int longTotal();
    return long_cnt[0] + long_cnt[1] + long_cnt[2] + long_cnt[3];
  endfunction

  initial begin
    clearCounts();

    // Reset: all outputs low while held
    run(3);
    checkOutput("reset_outputs", int'({Key_State, Press_Pulse, Release_Pulse, Long_Pulse}), 0);
    RSTn = 1'b1;
    run(40);
    checkOutput("idle_no_press", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3], 0);
    checkOutput("idle_state", int'(Key_State), 0);

    // 1. Clean press on key 0
    $display("[TB] step 1: clean press");
    clearCounts();
    applyStimulus(4'b1110);
    run(100);
    checkOutput("t1_press_count", press_cnt[0], 1);
    checkOutput("t1_press_window", inWindow(press_at[0] - t0), 1);
    checkOutput("t1_state", int'(Key_State), 1);
    checkOutput("t1_other_press", press_cnt[1] + press_cnt[2] + press_cnt[3], 0);
    checkOutput("t1_no_release", rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3], 0);
    applyStimulus(4'b1111);
    run(60);
    checkOutput("t1_release_count", rel_cnt[0], 1);
    checkOutput("t1_release_window", inWindow(rel_at[0] - t0), 1);
    checkOutput("t1_state_after_rel", int'(Key_State), 0);

    // 2. Bounce for 60 cycles then hold key 1
    $display("[TB] step 2: bounce then hold");
    clearCounts();
    for (int s = 0; s < 12; s++) begin
      applyStimulus((s % 2 == 0) ? 4'b1101 : 4'b1111);
      run(4);
    end
    checkOutput("t2_no_pulse_bounce", press_cnt[1] + rel_cnt[1], 0);
    applyStimulus(4'b1101);
    run(50);
    checkOutput("t2_press_count", press_cnt[1], 1);
    checkOutput("t2_press_window", inWindow(press_at[1] - t0), 1);
    checkOutput("t2_state", int'(Key_State), 2);
    applyStimulus(4'b1111);
    run(50);
    checkOutput("t2_state_after_rel", int'(Key_State), 0);

    // 3. Short glitch on key 2
    $display("[TB] step 3: glitch rejection");
    clearCounts();
    applyStimulus(4'b1011);
    run(14);
    applyStimulus(4'b1111);
    run(50);
    checkOutput("t3_no_pulse", press_cnt[2] + rel_cnt[2], 0);
    checkOutput("t3_state", int'(Key_State[2]), 0);

    // 4. Simultaneous press and release of keys 0 and 3
    $display("[TB] step 4: simultaneous events");
    clearCounts();
    applyStimulus(4'b0110);
    run(100);
    checkOutput("t4_press_counts", press_cnt[0] * 10 + press_cnt[3], 11);
    checkOutput("t4_press_vec", int'(press_vec), 9);
    checkOutput("t4_press_same_cycle", press_at[0] - press_at[3], 0);
    checkOutput("t4_state", int'(Key_State), 9);
    applyStimulus(4'b1111);
    run(60);
    checkOutput("t4_release_counts", rel_cnt[0] * 10 + rel_cnt[3], 11);
    checkOutput("t4_release_vec", int'(rel_vec), 9);
    checkOutput("t4_release_same_cycle", rel_at[0] - rel_at[3], 0);
    checkOutput("t4_state_after_rel", int'(Key_State), 0);

    // 5. Reset while key 0 is in its press check
    $display("[TB] step 5: reset mid-check");
    clearCounts();
    applyStimulus(4'b1110);
    run(8);
    checkOutput("t5_no_early_press", press_cnt[0], 0);
    RSTn = 1'b0;
    #1;
    checkOutput("t5_reset_outputs", int'({Key_State, Press_Pulse, Release_Pulse, Long_Pulse}), 0);
    run(3);
    checkOutput("t5_reset_held", int'({Key_State, Press_Pulse, Release_Pulse, Long_Pulse}), 0);
    RSTn = 1'b1;
    t0 = cyc;
    clearCounts();
    run(40);
    checkOutput("t5_press_count", press_cnt[0], 1);
    checkOutput("t5_press_delay", press_at[0] - t0, 30);
    checkOutput("t5_state", int'(Key_State), 1);
    applyStimulus(4'b1111);
    run(60);
    checkOutput("t5_state_after_rel", int'(Key_State), 0);

    // 6. Long hold on key 1
    $display("[TB] step 6: long press");
    clearCounts();
    applyStimulus(4'b1101);
    run(200);
    checkOutput("t6_press_count", press_cnt[1], 1);
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    checkOutput("t6_long_count", long_cnt[1], 1);
    checkOutput("t6_long_delay", long_at[1] - press_at[1], 80);
    checkOutput("t6_long_other", longTotal() - long_cnt[1], 0);
`else
    checkOutput("t6_long_absent", longTotal(), 0);
`endif
    applyStimulus(4'b1111);
    run(60);
    checkOutput("t6_release_count", rel_cnt[1], 1);
    checkOutput("t6_state_after_rel", int'(Key_State), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/key_debounce_multi.md
Name: key_debounce_multi

Overview:
- Parametrised N-channel push-button debouncer for the board I/O layer. It replaces single-key, edge-input delay blocks.
- Samples raw key pins directly, synchronises them, and filters bounce with a shared 1 ms tick.
- Per channel it outputs a debounced level, a one-cycle press pulse and a one-cycle release pulse. These feed buzzer, LED and menu controllers.

Parameters:
- N_KEYS, 4, number of independent key channels.
- CLK_HZ, 50_000_000, input clock frequency in Hz. Must be a multiple of 1000 and at least 2000.
- DEBOUNCE_MS, 10, required stable time in ms. Minimum 2.
- ACTIVE_LOW, 1, 1 = pin low means pressed; 0 = pin high means pressed.
- LONG_MS, 1000, long-press threshold in ms, counted from press confirmation. Used only with LONG_PRESS_EN; must be greater than DEBOUNCE_MS.

Ports:
- CLK  in  1  system clock
- RSTn  in  1  reset, asynchronous, active-low
- Key_In  in  N_KEYS  raw asynchronous key pins
- Key_State  out  N_KEYS  debounced level, 1 = pressed
- Press_Pulse  out  N_KEYS  one-cycle pulse on confirmed press
- Release_Pulse  out  N_KEYS  one-cycle pulse on confirmed release
- Long_Pulse  out  N_KEYS  one-cycle pulse on long press (tied 0 without LONG_PRESS_EN)

Behaviour:
- Reset: the async reset clears every register.
  - All outputs are 0; prescaler is 0; every channel is in UP.
  - Synchroniser flops reset to the released pin level (1 if ACTIVE_LOW).
  - A key held through reset release is therefore debounced and reported as a press.
- Tick prescaler:
  - Shared, free-running, counts 0..CLK_HZ/1000-1.
  - Tick = 1 for one cycle at terminal count, then wraps to 0.
- Synchroniser: 2 flops per channel, then polarity normalised to p = 1 when pressed. Latency is 2 cycles.
- Per-channel FSM: states UP, CHK_DN, DOWN, CHK_UP. Ms counter width is $clog2(max(DEBOUNCE_MS, LONG_MS) + 1).
  - UP: if p = 1, go to CHK_DN and clear cnt.
  - CHK_DN:
    - p = 0: return to UP, no pulse (glitch rejected). This has priority over the tick.
    - Tick and cnt == DEBOUNCE_MS-1: go to DOWN, Key_State <= 1, Press_Pulse <= 1, cnt <= 0.
    - Other ticks: cnt + 1.
  - DOWN: if p = 0, go to CHK_UP and clear cnt. With LONG_PRESS_EN, cnt keeps counting ticks here (see Optional Feature).
  - CHK_UP: mirror of CHK_DN.
    - p = 1: return to DOWN with no pulse; the long-press count restarts.
    - Confirm: go to UP, Key_State <= 0, Release_Pulse <= 1.
- Timing:
  - Confirmation happens on the DEBOUNCE_MS-th tick after entering the check state.
  - Required stable time is therefore (DEBOUNCE_MS-1)*CLK_HZ/1000+1 to DEBOUNCE_MS*CLK_HZ/1000 cycles, plus 2 cycles of synchroniser latency.
- Pulses are registered and last exactly 1 cycle. Key_State changes on the same edge the pulse rises.
- Channels are fully independent. Any combination of pulses may occur in the same cycle.
- Counters saturate, never wrap. In DOWN, cnt holds at LONG_MS.

Optional Feature:
- Macro: KEY_DEBOUNCE_LONG_PRESS_EN.
- Defined:
  - In DOWN, cnt increments on each tick.
  - When cnt reaches LONG_MS-1 on a tick, Long_Pulse[ch] fires for one cycle, exactly LONG_MS*CLK_HZ/1000 cycles after Press_Pulse.
  - It fires at most once per press; cnt then saturates.
  - A bounce (DOWN→CHK_UP→DOWN) restarts the count.
- Not defined: no long-press logic is synthesised, and Long_Pulse is constant 0.

Test Plan (bench: CLK_HZ=10_000 so 10 cycles/ms, DEBOUNCE_MS=3, LONG_MS=8, N_KEYS=4, ACTIVE_LOW=1):
1. Clean press: Key_In[0] 1→0, held 100 cycles → exactly one Press_Pulse[0] 23..33 cycles after the edge; Key_State[0]=1 afterwards; all other outputs 0.
2. Bounce then hold: Key_In[1] toggles every 5 cycles for 60 cycles, then held low → no pulse during the toggling; exactly one Press_Pulse[1] 23..33 cycles after the last falling edge.
3. Glitch rejection: Key_In[2] low for 15 cycles then high → no Press_Pulse or Release_Pulse; Key_State[2] stays 0.
4. Release plus simultaneous events: press Key_In[0] and Key_In[3] on the same cycle, release both after 100 cycles → Press_Pulse=4'b1001 in a single cycle; later Release_Pulse=4'b1001 in a single cycle; Key_State returns to 0.
5. Reset mid-check: Key_In[0] low, RSTn pulsed low 3 cycles while in CHK_DN, key kept low → all outputs 0 during reset; one Press_Pulse[0] 23..33 cycles after RSTn rises.
6. Long press (macro defined): hold Key_In[1] low for 200 cycles → Long_Pulse[1] exactly once, 80 cycles after Press_Pulse[1]. With the macro undefined, Long_Pulse stays 0.
